fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage upstream of the main/ALU decoder. Holds the fetch PC, issues
//  word requests to instruction memory (at most one outstanding) and buffers returned
//  words in a DEPTH-entry prefetch FIFO. Presents the head instruction with valid/ready,
//  pre-split into the decoder's Op/Funct/Rd/sh fields. Flushes on branch redirect.
// PARAMETERS
//  DEPTH     4             prefetch FIFO entries; power of two, >=2
//  RESET_PC  32'h0000_0000 fetch address after reset; word aligned
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  imem_req     out  1   request valid
//  imem_addr    out  32  request address; [1:0]=2'b00
//  imem_gnt     in   1   request accepted this cycle (only meaningful with imem_req)
//  imem_rvalid  in   1   read data valid
//  imem_rdata   in   32  read data
//  redirect     in   1   branch taken / PC write: flush and refetch
//  redirect_pc  in   32  new fetch address; [1:0] ignored
//  instr_valid  out  1   head entry valid
//  instr_ready  in   1   consumer takes head when instr_valid & instr_ready
//  instr        out  32  head instruction word
//  pc_plus8     out  32  head entry address + 8 (ARM PC read value)
//  cond         out  4   instr[31:28]
//  Op           out  2   instr[27:26]
//  Funct        out  6   instr[25:20]
//  Rd           out  4   instr[15:12]
//  sh           out  2   instr[6:5]
// BEHAVIOUR
//  Clock: clk only. Reset: asynchronous, active-low (rst_n).
//  Reset: fetch_pc=RESET_PC, FIFO count=0, state IDLE. imem_req=0, instr_valid=0; instr,
//   pc_plus8 and all field outputs 0 (FIFO storage cleared).
//  States: IDLE (none outstanding), WAIT (one outstanding, live), DROP (one outstanding, stale).
//  imem_req = (state==IDLE) & ~redirect & (count < DEPTH). imem_addr = fetch_pc. Both combinational.
//  IDLE: imem_req & imem_gnt -> WAIT; req_pc<=fetch_pc; fetch_pc<=fetch_pc+4 (mod 2^32).
//  WAIT: imem_rvalid & ~redirect -> push {imem_rdata, req_pc}; -> IDLE.
//        redirect & imem_rvalid -> data discarded; -> IDLE.
//        redirect & ~imem_rvalid -> DROP.
//  DROP: imem_rvalid -> data discarded; -> IDLE. Redirect in DROP stays DROP, fetch_pc updated.
//  imem_rvalid in IDLE is ignored (covers responses to requests issued before reset).
//  Credit: a request issues only if count<DEPTH, and requests are issued only in IDLE, so at
//   most one in flight; a push therefore always finds a free slot.
//  Redirect (any state): count<=0, fetch_pc<={redirect_pc[31:2],2'b00}; it overrides a
//   same-cycle push and pop. The first new request may issue the cycle after redirect
//   (IDLE) or after the stale response returns (DROP).
//  Output: instr_valid = (count!=0). instr/pc_plus8/fields are driven from the FIFO head
//   with zero latency. Pop on instr_valid & instr_ready & ~redirect.
//  Simultaneous push+pop: count unchanged, both pointers advance. Pointers wrap mod DEPTH.
//  Throughput: one word per 2 cycles minimum (req, then rvalid next cycle, req again).
//  Latency: rvalid in cycle N -> instr_valid in cycle N+1 if the FIFO was empty.
//  Mid-operation reset: all state cleared immediately; no handshake with imem is pending.
// TESTING
//  1 Release reset, gnt=1, rvalid 1 cycle after grant, ready=1 -> imem_addr 0,4,8,...;
//    instr appears in order with pc_plus8=8,12,16.
//  2 ready=0, DEPTH=4 -> 4 words accepted, then imem_req stays 0; raise ready -> one pop per
//    cycle, requests resume once count<4.
//  3 redirect, redirect_pc=32'h100 in WAIT, rvalid next cycle -> word dropped, instr_valid=0,
//    next imem_addr=32'h100.
//  4 redirect_pc=32'h0000_0103 -> imem_addr=32'h100; redirect_pc=32'hFFFF_FFFC -> addresses
//    FFFF_FFFC, then 0000_0000.
//  5 imem_rdata=32'hE3A0_1005 -> cond=4'hE, Op=2'b00, Funct=6'b111010, Rd=4'h1, sh=2'b00.
//  6 rst_n low while in WAIT, rvalid after release before any grant -> ignored;
//    instr_valid=0, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one imem word request at a time, buffers returned words
// in a prefetch FIFO and presents the head word pre-split into decoder fields.
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] pc_plus8,
   output logic [3:0]  cond,
   output logic [1:0]  Op,
   output logic [5:0]  Funct,
   output logic [3:0]  Rd,
   output logic [1:0]  sh
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t        state_q;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   req_pc_q;
   logic [AW:0]   count_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [31:0]   word_q [DEPTH];
   logic [31:0]   pc8_q  [DEPTH];
   logic          issue_s;
   logic          push_s;
   logic          pop_s;
   logic          unused_ok_s;

   // Requests only from IDLE with a free slot guaranteed for the returning word.
   assign imem_req    = rst_n & (state_q == S_IDLE) & ~redirect & (count_q < FULL);
   assign imem_addr   = fetch_pc_q;
   assign issue_s     = imem_req & imem_gnt;
   assign push_s      = (state_q == S_WAIT) & imem_rvalid & ~redirect;
   assign instr_valid = (count_q != (AW+1)'(0));
   assign pop_s       = instr_valid & instr_ready & ~redirect;
   assign unused_ok_s = ^redirect_pc[1:0];

   // The stored value is already pc+8 so cleared storage reads back as zero.
   assign instr    = word_q[rd_ptr_q];
   assign pc_plus8 = pc8_q[rd_ptr_q];
   assign cond     = instr[31:28];
   assign Op       = instr[27:26];
   assign Funct    = instr[25:20];
   assign Rd       = instr[15:12];
   assign sh       = instr[6:5];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= 32'h0000_0000;
         count_q    <= (AW+1)'(0);
         wr_ptr_q   <= AW'(0);
         rd_ptr_q   <= AW'(0);
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= 32'h0000_0000;
            pc8_q[i]  <= 32'h0000_0000;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (issue_s) begin
                  state_q    <= S_WAIT;
                  req_pc_q   <= fetch_pc_q;
                  fetch_pc_q <= fetch_pc_q + 32'd4;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state_q <= S_IDLE;
               end else if (redirect) begin
                  state_q <= S_DROP;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (push_s) begin
            word_q[wr_ptr_q] <= imem_rdata;
            pc8_q[wr_ptr_q]  <= req_pc_q + 32'd8;
            wr_ptr_q         <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end

         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase

         // Redirect wins over any same-cycle push/pop; an in-flight word becomes stale.
         if (redirect) begin
            count_q    <= (AW+1)'(0);
            wr_ptr_q   <= AW'(0);
            rd_ptr_q   <= AW'(0);
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with programmable latency, scoreboard of expected
// head words, a decode-field vector table and hand sequences for redirect/reset corners.
module tb_fetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk, rst_n;
   logic        imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc_plus8;
   logic [3:0]  cond, Rd;
   logic [1:0]  Op, sh;
   logic [5:0]  Funct;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .pc_plus8(pc_plus8),
      .cond(cond), .Op(Op), .Funct(Funct), .Rd(Rd), .sh(sh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc8;
   } exp_t;

   typedef struct {
      logic [31:0] word;
      logic [3:0]  c;
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [3:0]  rd;
      logic [1:0]  s;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl[5];
   int          total, bad;
   int          pend_cnt, lat;
   logic        pend, pend_live, pend_rst, granted;
   logic [31:0] pend_addr, pend_data, exp_pc;
   logic        gnt_en, rdy, rd_en, ovr_en;
   logic [31:0] rd_pc, ovr_data;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ovr_en ? ovr_data : {~a[15:0], a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: entered and left at posedge+1.
   task automatic cycle();
      logic rv;
      exp_t e;
      if (pend) pend_cnt--;
      rv          = pend && (pend_cnt == 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? pend_data : 32'hDEAD_BEEF;
      imem_gnt    = gnt_en;
      redirect    = rd_en;
      redirect_pc = rd_pc;
      instr_ready = rdy;
      #1;
      if (!pend_rst) begin
         if (pend || redirect || sb.size() >= DEPTH) chk("req_off", 32'(imem_req), 32'd0);
         else chk("req_on", 32'(imem_req), 32'd1);
      end
      chk("valid", 32'(instr_valid), 32'(sb.size() != 0));
      if (instr_valid && instr_ready && !redirect) begin
         if (sb.size() == 0) begin
            chk("pop_empty", 32'(instr_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("instr", instr, e.word);
            chk("pc_plus8", pc_plus8, e.pc8);
         end
      end
      if (rv) begin
         if (pend_live && !redirect) begin
            e.word = pend_data;
            e.pc8  = pend_addr + 32'd8;
            sb.push_back(e);
         end
         pend     = 1'b0;
         pend_rst = 1'b0;
      end
      granted = 1'b0;
      if (imem_req && imem_gnt) begin
         chk("addr", imem_addr, exp_pc);
         pend      = 1'b1;
         pend_live = 1'b1;
         pend_cnt  = lat;
         pend_addr = imem_addr;
         pend_data = mem_word(imem_addr);
         exp_pc    = exp_pc + 32'd4;
         granted   = 1'b1;
      end
      if (redirect) begin
         sb.delete();
         exp_pc = {rd_pc[31:2], 2'b00};
         if (pend) pend_live = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc8", pc_plus8, 32'd0);
      chk("rst_fields", 32'({cond, Op, Funct, Rd, sh}), 32'd0);
      sb.delete();
      exp_pc = RESET_PC;
      if (pend) begin
         pend_live = 1'b0;
         pend_rst  = 1'b1;
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input string name);
      for (int k = 0; k < 12 && !granted; k++) cycle();
      chk(name, 32'(granted), 32'd1);
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      redirect = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
      pend = 1'b0; pend_live = 1'b0; pend_rst = 1'b0; pend_cnt = 0; granted = 1'b0;
      pend_addr = 32'd0; pend_data = 32'd0; exp_pc = RESET_PC;
      lat = 1; gnt_en = 1'b1; rdy = 1'b1; rd_en = 1'b0; rd_pc = 32'd0;
      ovr_en = 1'b0; ovr_data = 32'd0;
      tbl[0] = '{32'hE3A0_1005, 4'hE, 2'b00, 6'b111010, 4'h1, 2'b00};
      tbl[1] = '{32'hE591_2004, 4'hE, 2'b01, 6'b011001, 4'h2, 2'b00};
      tbl[2] = '{32'h0A00_0003, 4'h0, 2'b10, 6'b100000, 4'h0, 2'b00};
      tbl[3] = '{32'hE1A0_1062, 4'hE, 2'b00, 6'b011010, 4'h1, 2'b11};
      tbl[4] = '{32'h4C3F_7FA0, 4'h4, 2'b11, 6'b000011, 4'h7, 2'b01};

      @(posedge clk);
      #1;
      apply_reset();

      // Streaming fetch from reset
      for (int i = 0; i < 16; i++) cycle();

      // Back-pressure fills the FIFO, then drains
      rdy = 1'b0;
      for (int i = 0; i < 14; i++) cycle();
      chk("full_req", 32'(imem_req), 32'd0);
      chk("full_valid", 32'(instr_valid), 32'd1);
      rdy = 1'b1;
      for (int i = 0; i < 12; i++) cycle();

      // Redirect while waiting; the late word must be dropped
      lat = 2; rdy = 1'b0;
      rd_en = 1'b1; rd_pc = 32'h0000_0040; cycle(); rd_en = 1'b0;
      wait_grant("t3_grant");
      rd_en = 1'b1; rd_pc = 32'h0000_0100; cycle(); rd_en = 1'b0;
      cycle();
      chk("t3_drop_valid", 32'(instr_valid), 32'd0);
      chk("t3_req", 32'(imem_req), 32'd1);
      chk("t3_addr", imem_addr, 32'h0000_0100);

      // Redirect again while already dropping
      lat = 3;
      wait_grant("t3b_grant");
      rd_en = 1'b1; rd_pc = 32'h0000_0200; cycle();
      rd_pc = 32'h0000_0300; cycle(); rd_en = 1'b0;
      for (int i = 0; i < 10; i++) cycle();

      // Misaligned redirect and address wrap
      lat = 1; rdy = 1'b1;
      rd_en = 1'b1; rd_pc = 32'h0000_0103; cycle(); rd_en = 1'b0;
      wait_grant("t4_grant");
      chk("t4_align", pend_addr, 32'h0000_0100);
      for (int i = 0; i < 4; i++) cycle();
      rd_en = 1'b1; rd_pc = 32'hFFFF_FFFC; cycle(); rd_en = 1'b0;
      wait_grant("t4_grant0");
      chk("t4_wrap0", pend_addr, 32'hFFFF_FFFC);
      cycle();
      wait_grant("t4_grant1");
      chk("t4_wrap1", pend_addr, 32'h0000_0000);
      for (int i = 0; i < 4; i++) cycle();

      // Decode field table
      ovr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rdy = 1'b0; ovr_data = tbl[i].word;
         rd_en = 1'b1; rd_pc = 32'h0000_2000 + 32'(i * 16); cycle(); rd_en = 1'b0;
         for (int k = 0; k < 10 && !instr_valid; k++) cycle();
         chk("tbl_valid", 32'(instr_valid), 32'd1);
         chk("tbl_cond", 32'(cond), 32'(tbl[i].c));
         chk("tbl_op", 32'(Op), 32'(tbl[i].op));
         chk("tbl_funct", 32'(Funct), 32'(tbl[i].fn));
         chk("tbl_rd", 32'(Rd), 32'(tbl[i].rd));
         chk("tbl_sh", 32'(sh), 32'(tbl[i].s));
         rdy = 1'b1; cycle();
      end
      ovr_en = 1'b0;

      // Reset while a request is outstanding; the late response must be ignored
      lat = 3; rdy = 1'b1;
      rd_en = 1'b1; rd_pc = 32'h0000_0500; cycle(); rd_en = 1'b0;
      wait_grant("t6_grant");
      gnt_en = 1'b0;
      apply_reset();
      for (int i = 0; i < 4; i++) cycle();
      chk("t6_valid", 32'(instr_valid), 32'd0);
      chk("t6_req", 32'(imem_req), 32'd1);
      chk("t6_addr", imem_addr, RESET_PC);
      gnt_en = 1'b1; lat = 1;
      for (int i = 0; i < 12; i++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
